// File: rtl/conv_sequencer_if.sv
// Bundle between the convolution sequencer and its register bank, memories, MAC and output writer.
// Handshake: a transfer on out_* happens on a rising edge where out_valid && out_ready; while out_valid is high and out_ready is low, out_addr/out_data/out_valid stay stable.
interface conv_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10,
  parameter int DATA_W = 32
);
  logic              cfg_start;
  logic              cfg_abort;
  logic [ADDR_W-1:0] cfg_img_base;
  logic [ADDR_W-1:0] cfg_out_base;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic [2:0]        cfg_ksize;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [ADDR_W-1:0] pix_raddr;
  logic [5:0]        coef_raddr;
  logic              rd_en;
  logic              mac_first;
  logic              mac_last;
  logic              acc_valid;
  logic [DATA_W-1:0] acc_data;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [2:0]        state;

  modport master (
    input  cfg_start, cfg_abort, cfg_img_base, cfg_out_base, cfg_width, cfg_height, cfg_ksize,
    input  acc_valid, acc_data, out_ready,
    output busy, done, cfg_err, pix_raddr, coef_raddr, rd_en, mac_first, mac_last,
    output out_valid, out_addr, out_data, state
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_img_base, cfg_out_base, cfg_width, cfg_height, cfg_ksize,
    output acc_valid, acc_data, out_ready,
    input  busy, done, cfg_err, pix_raddr, coef_raddr, rd_en, mac_first, mac_last,
    input  out_valid, out_addr, out_data, state
  );
endinterface

// File: rtl/conv_sequencer.sv
// Control FSM walking every valid output window of an image, issuing one pixel/coefficient read per
// cycle, collecting the MAC result and handing it to the output writer.
module conv_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10,
  parameter int K_MAX  = 7,
  parameter int DATA_W = 32
) (
  input logic ACLK,
  input logic ARESET,
  conv_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_TAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] img_base, out_base;
  logic [DIM_W-1:0]  width, height;
  logic [2:0]        ksize;
  logic [DIM_W-1:0]  ox, oy;
  logic [2:0]        kx, ky;
  logic [5:0]        coef;
  logic [ADDR_W-1:0] line_base, win_base, row_addr, pix_addr, out_ptr;
  logic [DATA_W-1:0] result;
  logic              err;

  logic [DIM_W-1:0]  k_ext;
  logic [ADDR_W-1:0] w_ext;
  logic              cfg_bad, last_kx, last_ky, last_ox, last_oy, tap, write;

  assign k_ext   = {{(DIM_W-3){1'b0}}, ksize};
  assign w_ext   = ADDR_W'(width);
  assign cfg_bad = !ksize[0] || (32'(ksize) > 32'(K_MAX)) || (k_ext > width) || (k_ext > height);
  assign last_kx = (kx == ksize - 3'd1);
  assign last_ky = (ky == ksize - 3'd1);
  assign last_ox = (ox == width - k_ext);
  assign last_oy = (oy == height - k_ext);
  assign tap     = (state == S_TAP);
  assign write   = (state == S_WRITE);

  // Addresses advance incrementally: line_base = row of the window origin, win_base = window
  // origin, row_addr = current kernel row start, pix_addr = current tap.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= S_IDLE;  err <= 1'b0;
      img_base <= '0;   out_base <= '0;  width <= '0;  height <= '0;  ksize <= '0;
      ox <= '0;  oy <= '0;  kx <= '0;  ky <= '0;  coef <= '0;
      line_base <= '0;  win_base <= '0;  row_addr <= '0;  pix_addr <= '0;  out_ptr <= '0;
      result <= '0;
    end else if (state != S_IDLE && bus.cfg_abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.cfg_start) begin
          img_base <= bus.cfg_img_base;  out_base <= bus.cfg_out_base;
          width    <= bus.cfg_width;     height   <= bus.cfg_height;
          ksize    <= bus.cfg_ksize;
          state    <= S_CHECK;
        end
        S_CHECK: if (cfg_bad) begin
          err   <= 1'b1;
          state <= S_DONE;
        end else begin
          err <= 1'b0;
          ox <= '0;  oy <= '0;  kx <= '0;  ky <= '0;  coef <= '0;
          line_base <= img_base;  win_base <= img_base;
          row_addr  <= img_base;  pix_addr <= img_base;
          out_ptr   <= out_base;
          state     <= S_TAP;
        end
        S_TAP: begin
          coef <= coef + 6'd1;
          if (last_kx) begin
            kx       <= '0;
            row_addr <= row_addr + w_ext;
            pix_addr <= row_addr + w_ext;
            if (last_ky) begin
              ky    <= '0;
              state <= S_WAIT;
            end else begin
              ky <= ky + 3'd1;
            end
          end else begin
            kx       <= kx + 3'd1;
            pix_addr <= pix_addr + 1'b1;
          end
        end
        S_WAIT: if (bus.acc_valid) begin
          result <= bus.acc_data;
          state  <= S_WRITE;
        end
        S_WRITE: if (bus.out_ready) begin
          out_ptr <= out_ptr + 1'b1;
          coef    <= '0;
          if (last_ox && last_oy) begin
            state <= S_DONE;
          end else begin
            state <= S_TAP;
            if (last_ox) begin
              ox        <= '0;
              oy        <= oy + 1'b1;
              line_base <= line_base + w_ext;
              win_base  <= line_base + w_ext;
              row_addr  <= line_base + w_ext;
              pix_addr  <= line_base + w_ext;
            end else begin
              ox       <= ox + 1'b1;
              win_base <= win_base + 1'b1;
              row_addr <= win_base + 1'b1;
              pix_addr <= win_base + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by state so an abort or reset clears them immediately.
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.cfg_err    = err;
  assign bus.rd_en      = tap;
  assign bus.pix_raddr  = tap ? pix_addr : '0;
  assign bus.coef_raddr = tap ? coef : '0;
  assign bus.mac_first  = tap && (kx == 3'd0) && (ky == 3'd0);
  assign bus.mac_last   = tap && last_kx && last_ky;
  assign bus.out_valid  = write;
  assign bus.out_addr   = write ? out_ptr : '0;
  assign bus.out_data   = write ? result : '0;
  assign bus.state      = state;
endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: a plain reference model predicts every read tap and output address,
// a MAC responder supplies results, and a monitor compares everything the DUT presents.
module tb_conv_sequencer;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 10;
  localparam int K_MAX  = 7;
  localparam int DATA_W = 32;

  logic ACLK;
  logic ARESET;

  conv_sequencer_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .DATA_W(DATA_W)) bus ();

  conv_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .K_MAX(K_MAX), .DATA_W(DATA_W)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // scoreboard state
  logic [23:0] exp_rd_q[$];    // {first, last, coef[5:0], pix[15:0]}
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int n_checks, n_errors;
  int rd_cnt, out_cnt, done_cnt, stall_cnt;
  int rd0, out0, done0, stall0;
  int mac_lat, ready_mode, inject_seq;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // reference model: every valid window in raster order, taps kx inner / ky outer
  task automatic model_job(input logic [15:0] img, input logic [15:0] outb, input int w, input int h, input int k);
    for (int oy = 0; oy <= h - k; oy++)
      for (int ox = 0; ox <= w - k; ox++) begin
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            logic [15:0] p;
            logic f, l;
            p = 16'(int'(img) + (oy + ky) * w + ox + kx);
            f = (kx == 0 && ky == 0);
            l = (kx == k - 1 && ky == k - 1);
            exp_rd_q.push_back({f, l, 6'(ky * k + kx), p});
          end
        exp_addr_q.push_back(16'(int'(outb) + oy * (w - k + 1) + ox));
      end
  endtask

  // driver tasks
  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    exp_rd_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic start_job(input logic [15:0] img, input logic [15:0] outb, input int w, input int h,
                           input int k, input bit valid);
    exp_rd_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    if (valid) model_job(img, outb, w, h, k);
    rd0 = rd_cnt; out0 = out_cnt; done0 = done_cnt; stall0 = stall_cnt;
    @(posedge ACLK); #1;
    bus.cfg_img_base = img;  bus.cfg_out_base = outb;
    bus.cfg_width = DIM_W'(w);  bus.cfg_height = DIM_W'(h);  bus.cfg_ksize = 3'(k);
    bus.cfg_start = 1'b1;
    @(posedge ACLK); #1;
    bus.cfg_start = 1'b0;
    bus.cfg_img_base = 16'($urandom());  bus.cfg_out_base = 16'($urandom());
    bus.cfg_width = DIM_W'($urandom());  bus.cfg_height = DIM_W'($urandom());
    bus.cfg_ksize = 3'($urandom());
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!bus.done && n < budget);
    if (!bus.done) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      check({name, "_busy_at_done"}, bus.busy, 1);
      @(negedge ACLK);
      check({name, "_busy_after_done"}, bus.busy, 0);
      check({name, "_done_single"}, bus.done, 0);
    end
  endtask

  task automatic end_checks(input string name, input int reads, input int outs);
    @(negedge ACLK);
    check({name, "_rd_count"}, 64'(rd_cnt - rd0), 64'(reads));
    check({name, "_out_count"}, 64'(out_cnt - out0), 64'(outs));
    check({name, "_done_count"}, 64'(done_cnt - done0), 1);
    check({name, "_rd_q_left"}, 64'(exp_rd_q.size()), 0);
    check({name, "_out_q_left"}, 64'(exp_addr_q.size()), 0);
  endtask

  task automatic invalid_job(input string name, input int w, input int h, input int k);
    start_job(16'h0040, 16'h0080, w, h, k, 1'b0);
    @(negedge ACLK);
    check({name, "_done_early"}, bus.done, 0);
    check({name, "_busy_check"}, bus.busy, 1);
    @(negedge ACLK);
    check({name, "_done"}, bus.done, 1);
    check({name, "_cfg_err"}, bus.cfg_err, 1);
    @(negedge ACLK);
    check({name, "_busy_after"}, bus.busy, 0);
    check({name, "_no_reads"}, 64'(rd_cnt - rd0), 0);
  endtask

  // MAC responder: result arrives mac_lat cycles after mac_last
  initial begin : mac_model
    int pend, seen;
    bit hit;
    pend = 0; seen = 0;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    forever begin
      @(negedge ACLK);
      hit = bus.rd_en && bus.mac_last && !ARESET;
      @(posedge ACLK); #1;
      bus.acc_valid = 1'b0;
      if (ARESET) pend = 0;
      if (hit) pend = mac_lat;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.acc_valid = 1'b1;
          bus.acc_data  = $urandom();
          exp_data_q.push_back(bus.acc_data);
        end
      end
      if (inject_seq != seen) begin
        seen = inject_seq;
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // output writer: mode 0 always ready, 1 random, 2 stall window 1 for five cycles
  initial begin : out_responder
    int hs_idx, stall_left;
    bit v, r, b;
    hs_idx = 0; stall_left = 5;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge ACLK);
      v = bus.out_valid; r = bus.out_ready; b = bus.busy;
      @(posedge ACLK); #1;
      if (!b) begin
        hs_idx = 0; stall_left = 5;
      end else begin
        if (v && r) hs_idx++;
        if (v && !r && stall_left > 0) stall_left--;
      end
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = !(hs_idx == 1 && stall_left > 0);
      endcase
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    logic        pv, pr;
    logic [15:0] pa;
    logic [31:0] pd;
    logic [23:0] e;
    pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        stall_cnt++;
        check("hold_valid", bus.out_valid, 1);
        check("hold_addr", bus.out_addr, pa);
        check("hold_data", bus.out_data, pd);
        check("stall_no_rd", bus.rd_en, 0);
      end
      if (bus.rd_en) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          e = exp_rd_q.pop_front();
          check("rd_tap", {bus.mac_first, bus.mac_last, bus.coef_raddr, bus.pix_raddr}, e);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          check("out_addr", bus.out_addr, exp_addr_q.pop_front());
          check("out_data", bus.out_data, exp_data_q.pop_front());
        end
      end
      if (bus.done) done_cnt++;
      pv = bus.out_valid; pr = bus.out_ready; pa = bus.out_addr; pd = bus.out_data;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin : main
    int n, w, h, k, m;
    n_checks = 0; n_errors = 0;
    rd_cnt = 0; out_cnt = 0; done_cnt = 0; stall_cnt = 0;
    rd0 = 0; out0 = 0; done0 = 0; stall0 = 0;
    mac_lat = 1; ready_mode = 0; inject_seq = 0;
    ARESET = 1'b1;
    bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0;
    bus.cfg_img_base = '0; bus.cfg_out_base = '0;
    bus.cfg_width = '0; bus.cfg_height = '0; bus.cfg_ksize = '0;
    do_reset();

    @(negedge ACLK);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pix_raddr", bus.pix_raddr, 0);
    check("rst_state", bus.state, 0);

    // basic 4x4, K=3
    mac_lat = 1; ready_mode = 0;
    start_job(16'h0100, 16'h0200, 4, 4, 3, 1'b1);
    wait_done("basic", 2000);
    end_checks("basic", 36, 4);

    // same job, slow MAC, writer stalls window 1
    mac_lat = 3; ready_mode = 2;
    start_job(16'h0100, 16'h0200, 4, 4, 3, 1'b1);
    wait_done("stall", 2000);
    end_checks("stall", 36, 4);
    check("stall_cycles", 64'(stall_cnt - stall0), 5);

    // K=1
    mac_lat = 1; ready_mode = 0;
    start_job(16'h0300, 16'h0400, 2, 1, 1, 1'b1);
    wait_done("k1", 500);
    end_checks("k1", 2, 2);

    // invalid configurations
    invalid_job("k4", 8, 8, 4);
    invalid_job("k0", 8, 8, 0);
    invalid_job("k5w3", 3, 8, 5);

    // a valid start clears cfg_err
    start_job(16'h1000, 16'h2000, 5, 3, 3, 1'b1);
    @(negedge ACLK);
    @(negedge ACLK);
    check("err_cleared", bus.cfg_err, 0);
    wait_done("clear", 2000);
    end_checks("clear", 27, 3);

    // abort during TAP of window 2, then a late acc_valid
    start_job(16'h0100, 16'h0200, 4, 4, 3, 1'b1);
    n = 0;
    while ((rd_cnt - rd0) < 22 && n < 1000) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("abort_reach_win2", 64'(rd_cnt - rd0), 22);
    bus.cfg_abort = 1'b1;
    @(posedge ACLK); #1;
    bus.cfg_abort = 1'b0;
    exp_rd_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    @(negedge ACLK);
    check("abort_busy", bus.busy, 0);
    check("abort_state", bus.state, 0);
    check("abort_rd_en", bus.rd_en, 0);
    inject_seq++;
    m = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (bus.out_valid || bus.busy) m++;
    end
    check("abort_quiet", 64'(m), 0);
    check("abort_no_done", 64'(done_cnt - done0), 0);
    check("abort_out_count", 64'(out_cnt - out0), 2);

    // start while busy with a new width must be ignored
    start_job(16'h0100, 16'h0200, 4, 4, 3, 1'b1);
    repeat (5) @(posedge ACLK);
    #1;
    bus.cfg_width = 10'd8; bus.cfg_img_base = 16'h0500; bus.cfg_start = 1'b1;
    @(posedge ACLK); #1;
    bus.cfg_start = 1'b0;
    wait_done("busy_start", 2000);
    end_checks("busy_start", 36, 4);

    // randomized jobs, including address wrap
    for (int j = 0; j < 6; j++) begin
      w = $urandom_range(1, 9);
      h = $urandom_range(1, 9);
      k = 2 * $urandom_range(0, 3) + 1;
      while (k > w || k > h) k -= 2;
      mac_lat = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 1);
      start_job(16'($urandom()), 16'($urandom_range(16'hFFC0, 16'hFFFF)), w, h, k, 1'b1);
      wait_done("rand", 20000);
      end_checks("rand", (w - k + 1) * (h - k + 1) * k * k, (w - k + 1) * (h - k + 1));
    end

    // reset clears cfg_err; reset mid-job returns to idle
    mac_lat = 1; ready_mode = 0;
    invalid_job("pre_rst", 2, 2, 3);
    do_reset();
    check("rst_clears_err", bus.cfg_err, 0);
    start_job(16'h0100, 16'h0200, 4, 4, 3, 1'b1);
    repeat (10) @(negedge ACLK);
    do_reset();
    @(negedge ACLK);
    check("midrst_busy", bus.busy, 0);
    check("midrst_state", bus.state, 0);
    check("midrst_out_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
